// File: rtl/led_pkg.sv
// ============================================================================
// Module  : led_pkg
// Brief   : Shared mode constants, state encoding and the pattern generator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

    localparam logic [1:0] MODE_ONCE     = 2'd0;
    localparam logic [1:0] MODE_LOOP     = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One-hot walk for the first WIDTH entries, then a shrinking bar of ones.
    function automatic logic [63:0] pattern(input int i, input int width);
        if (i < width)
            return 64'd1 << i;
        else
            return {64{1'b1}} << ((i - width) % width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_pattern_rom.sv
// ============================================================================
// Module  : led_pattern_rom
// Brief   : Constant pattern table with registered, enable-gated read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_rom
    import led_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MEM_ADDR = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [MEM_ADDR-1:0] addr,
    output logic [WIDTH-1:0]    data
);

    localparam int DEPTH = 2 ** MEM_ADDR;

    logic [WIDTH-1:0] rom_mem [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [63:0] C_ENTRY = pattern(i, WIDTH);
        assign rom_mem[i] = C_ENTRY[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            data <= '0;
        else
            data <= en ? rom_mem[addr] : '0;
    end

endmodule

`default_nettype wire

// File: rtl/led_pattern_seq.sv
// ============================================================================
// Module  : led_pattern_seq
// Brief   : Steps a pattern table through an address window (once/loop/ping-pong).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_seq
    import led_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MEM_ADDR = 4,
    parameter int DIV_W    = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [DIV_W-1:0]    step_div,
    input  logic [MEM_ADDR-1:0] first_addr,
    input  logic [MEM_ADDR-1:0] last_addr,
    output logic [WIDTH-1:0]    led_out,
    output logic [MEM_ADDR-1:0] cur_addr,
    output logic                busy,
    output logic                done
);

    state_t              state;
    logic [1:0]          mode_q;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    prescaler;
    logic [MEM_ADDR-1:0] first_q;
    logic [MEM_ADDR-1:0] last_q;
    logic                dir_up;

    logic                window_ok;
    logic                tick;
    logic [MEM_ADDR-1:0] addr_inc;
    logic [MEM_ADDR-1:0] addr_dec;

    assign window_ok = (first_addr <= last_addr);
    assign tick      = (prescaler == div_q);
    assign addr_inc  = cur_addr + 1'b1;
    assign addr_dec  = cur_addr - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_q    <= MODE_ONCE;
            div_q     <= '0;
            prescaler <= '0;
            first_q   <= '0;
            last_q    <= '0;
            dir_up    <= 1'b1;
            cur_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (start && window_ok) begin
                state     <= RUN;
                busy      <= 1'b1;
                mode_q    <= mode;
                div_q     <= step_div;
                first_q   <= first_addr;
                last_q    <= last_addr;
                cur_addr  <= first_addr;
                prescaler <= '0;
                dir_up    <= 1'b1;
            end else if (state == RUN) begin
                if (!tick) begin
                    prescaler <= prescaler + 1'b1;
                end else begin
                    prescaler <= '0;
                    case (mode_q)
                        MODE_ONCE: begin
                            if (cur_addr == last_q) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                cur_addr <= addr_inc;
                            end
                        end
                        MODE_PINGPONG: begin
                            // A single-entry window has nowhere to bounce to.
                            if (first_q != last_q) begin
                                if (dir_up) begin
                                    if (cur_addr == last_q) begin
                                        dir_up   <= 1'b0;
                                        cur_addr <= addr_dec;
                                    end else begin
                                        cur_addr <= addr_inc;
                                    end
                                end else begin
                                    if (cur_addr == first_q) begin
                                        dir_up   <= 1'b1;
                                        cur_addr <= addr_inc;
                                    end else begin
                                        cur_addr <= addr_dec;
                                    end
                                end
                            end
                        end
                        default: begin
                            cur_addr <= (cur_addr == last_q) ? first_q : addr_inc;
                        end
                    endcase
                end
            end
        end
    end

    led_pattern_rom #(
        .WIDTH    (WIDTH),
        .MEM_ADDR (MEM_ADDR)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state != IDLE),
        .addr  (cur_addr),
        .data  (led_out)
    );

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_seq.sv
// ============================================================================
// Module  : tb_led_pattern_seq
// Brief   : Directed vector table plus hand-written reset/ONCE-timing sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [23:0] step_div;
    logic [3:0]  first_addr;
    logic [3:0]  last_addr;
    logic [7:0]  led_out;
    logic [3:0]  cur_addr;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    led_pattern_seq #(.WIDTH(8), .MEM_ADDR(4), .DIV_W(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .step_div   (step_div),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .led_out    (led_out),
        .cur_addr   (cur_addr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stop;
        logic [1:0]  mode;
        logic [23:0] div;
        logic [3:0]  first;
        logic [3:0]  last;
        logic [7:0]  led;
        logic [3:0]  addr;
        logic        chk_addr;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vecs[$];

    // Idle cycle: config inputs carry junk to show they are ignored without start.
    task automatic idle(input logic [7:0] led, input logic [3:0] addr, input logic ca,
                        input logic b, input logic d);
        vec_t v;
        v = '{1'b0, 1'b0, 2'd0, 24'd5, 4'd12, 4'd14, led, addr, ca, b, d};
        vecs.push_back(v);
    endtask

    task automatic cmd(input logic st, input logic sp, input logic [1:0] m,
                       input logic [23:0] dv, input logic [3:0] f, input logic [3:0] l,
                       input logic [7:0] led, input logic [3:0] addr, input logic ca,
                       input logic b, input logic d);
        vec_t v;
        v = '{st, sp, m, dv, f, l, led, addr, ca, b, d};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] led, input logic [3:0] addr,
                         input logic ca, input logic b, input logic d);
        total++;
        if (led_out !== led || busy !== b || done !== d || (ca && cur_addr !== addr)) begin
            bad++;
            $display("FAIL %s: got led=%h addr=%0d busy=%b done=%b, want led=%h addr=%0d busy=%b done=%b",
                     name, led_out, cur_addr, busy, done, led, addr, b, d);
        end
    endtask

    task automatic drive_idle();
        start = 1'b0; stop = 1'b0; mode = 2'd0; step_div = 24'd0;
        first_addr = 4'd0; last_addr = 4'd0;
    endtask

    initial begin
        // Test 1: LOOP 0..3, dwell 2
        cmd(1, 0, 2'd1, 24'd1, 4'd0, 4'd3, 8'h00, 4'd0, 1, 1, 0);
        idle(8'h01, 4'd0, 1, 1, 0); idle(8'h01, 4'd1, 1, 1, 0);
        idle(8'h02, 4'd1, 1, 1, 0); idle(8'h02, 4'd2, 1, 1, 0);
        idle(8'h04, 4'd2, 1, 1, 0); idle(8'h04, 4'd3, 1, 1, 0);
        idle(8'h08, 4'd3, 1, 1, 0); idle(8'h08, 4'd0, 1, 1, 0);
        idle(8'h01, 4'd0, 1, 1, 0); idle(8'h01, 4'd1, 1, 1, 0);
        // Test 4: stop, then start+stop together
        cmd(0, 1, 2'd1, 24'd1, 4'd0, 4'd3, 8'h02, 4'd0, 0, 0, 0);
        idle(8'h00, 4'd0, 0, 0, 0);
        cmd(1, 1, 2'd1, 24'd0, 4'd0, 4'd3, 8'h00, 4'd0, 0, 0, 0);
        idle(8'h00, 4'd0, 0, 0, 0);
        // Test 2: ONCE 8..10
        cmd(1, 0, 2'd0, 24'd0, 4'd8, 4'd10, 8'h00, 4'd8, 1, 1, 0);
        idle(8'hFF, 4'd9, 1, 1, 0);
        idle(8'hFE, 4'd10, 1, 1, 0);
        idle(8'hFC, 4'd10, 1, 0, 1);
        idle(8'hFC, 4'd10, 1, 0, 0);
        idle(8'hFC, 4'd10, 1, 0, 0);
        // Test 3: PINGPONG 2..4, restarted from DONE
        cmd(1, 0, 2'd2, 24'd0, 4'd2, 4'd4, 8'hFC, 4'd2, 1, 1, 0);
        idle(8'h04, 4'd3, 1, 1, 0); idle(8'h08, 4'd4, 1, 1, 0);
        idle(8'h10, 4'd3, 1, 1, 0); idle(8'h08, 4'd2, 1, 1, 0);
        idle(8'h04, 4'd3, 1, 1, 0); idle(8'h08, 4'd4, 1, 1, 0);
        idle(8'h10, 4'd3, 1, 1, 0);
        // Test 5: invalid window during RUN ignored, then in IDLE
        cmd(1, 0, 2'd1, 24'd0, 4'd5, 4'd3, 8'h08, 4'd2, 1, 1, 0);
        cmd(0, 1, 2'd0, 24'd0, 4'd0, 4'd0, 8'h04, 4'd0, 0, 0, 0);
        idle(8'h00, 4'd0, 0, 0, 0);
        cmd(1, 0, 2'd1, 24'd0, 4'd5, 4'd3, 8'h00, 4'd0, 0, 0, 0);
        idle(8'h00, 4'd0, 0, 0, 0);
        // first == last LOOP holds, then ONCE single entry with dwell 3
        cmd(1, 0, 2'd1, 24'd0, 4'd7, 4'd7, 8'h00, 4'd7, 1, 1, 0);
        idle(8'h80, 4'd7, 1, 1, 0); idle(8'h80, 4'd7, 1, 1, 0); idle(8'h80, 4'd7, 1, 1, 0);
        cmd(1, 0, 2'd0, 24'd2, 4'd7, 4'd7, 8'h80, 4'd7, 1, 1, 0);
        idle(8'h80, 4'd7, 1, 1, 0); idle(8'h80, 4'd7, 1, 1, 0);
        idle(8'h80, 4'd7, 1, 0, 1); idle(8'h80, 4'd7, 1, 0, 0);

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("reset", 8'h00, 4'd0, 1, 0, 0);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            start = vecs[i].start; stop = vecs[i].stop; mode = vecs[i].mode;
            step_div = vecs[i].div; first_addr = vecs[i].first; last_addr = vecs[i].last;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), vecs[i].led, vecs[i].addr, vecs[i].chk_addr,
                     vecs[i].busy, vecs[i].done);
        end

        // Test 6: asynchronous reset between edges, then fresh run
        @(negedge clk);
        start = 1'b1; mode = 2'd1; step_div = 24'd0; first_addr = 4'd4; last_addr = 4'd6;
        @(negedge clk) drive_idle();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_rst", 8'h00, 4'd0, 1, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        start = 1'b1; mode = 2'd1; step_div = 24'd0; first_addr = 4'd0; last_addr = 4'd1;
        @(posedge clk); #1 check("post_rst0", 8'h00, 4'd0, 1, 1, 0);
        @(negedge clk) drive_idle();
        @(posedge clk); #1 check("post_rst1", 8'h01, 4'd1, 1, 1, 0);
        @(posedge clk); #1 check("post_rst2", 8'h02, 4'd0, 1, 1, 0);
        @(posedge clk); #1 check("post_rst3", 8'h01, 4'd1, 1, 1, 0);

        // ONCE 14..15, dwell 4: done expected exactly 8 edges after the start edge
        @(negedge clk);
        start = 1'b1; mode = 2'd0; step_div = 24'd3; first_addr = 4'd14; last_addr = 4'd15;
        @(posedge clk);
        @(negedge clk) drive_idle();
        begin
            int n;
            n = 0;
            while (!done && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            total++;
            if (n != 8) begin
                bad++;
                $display("FAIL once_latency: got %0d edges, want 8", n);
            end
            check("once_end", 8'h80, 4'd15, 1, 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
